uart_transmitter: RTL and testbench



---
 rtl/uart_transmitter.sv | 105 ++++++++++
 tb/tb_uart_transmitter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// UART transmit engine: frames a parallel word as start, LSB-first data, optional parity and stop bit.
// One bit per clk; clk is the baud-rate clock. All outputs are registered.
module uart_transmitter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  parity_type,
  input  logic                  parity_enable,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] parallel_data,
  output logic                  serial_data_out,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    par_en_q;
  logic                    par_bit_q;
  logic                    tx_q;
  logic                    busy_q;

  // state_q names the bit currently on the line; each edge loads the next bit.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (data_valid) begin
            shift_q   <= parallel_data;
            par_en_q  <= parity_enable;
            // Odd parity is the inverse of the even-parity XOR reduction.
            par_bit_q <= (^parallel_data) ^ parity_type;
            cnt_q     <= '0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= START;
          end
        end
        START: begin
          tx_q    <= shift_q[0];
          shift_q <= shift_q >> 1;
          state_q <= DATA;
        end
        DATA: begin
          if (cnt_q == LAST_BIT) begin
            cnt_q <= '0;
            if (par_en_q) begin
              tx_q    <= par_bit_q;
              state_q <= PARITY;
            end else begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
          end
        end
        PARITY: begin
          tx_q    <= 1'b1;
          state_q <= STOP;
        end
        STOP: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign serial_data_out = tx_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: stimulus queues hand-computed frames,
// a negedge monitor pops and compares every line bit and each busy run length.
module tb_uart_transmitter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         parity_type = 1'b0;
  logic         parity_enable = 1'b0;
  logic         data_valid = 1'b0;
  logic [W-1:0] parallel_data = '0;
  logic         serial_data_out;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic exp_bits[$];
  int   exp_len[$];
  int   run_len = 0;

  uart_transmitter #(.DATA_WIDTH(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .parity_type    (parity_type),
    .parity_enable  (parity_enable),
    .data_valid     (data_valid),
    .parallel_data  (parallel_data),
    .serial_data_out(serial_data_out),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Frame constants are written MSB=stop ... LSB=start; bits go out LSB first.
  task automatic push_frame(input logic [10:0] frame, input int len);
    for (int i = 0; i < len; i++) exp_bits.push_back(frame[i]);
    exp_len.push_back(len);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("reset_line", int'(serial_data_out), 1);
      check("reset_busy", int'(busy), 0);
      run_len = 0;
    end else if (busy === 1'b1) begin
      if (exp_bits.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_bit: got line %0b with no frame queued at %0t", serial_data_out, $time);
      end else begin
        check("frame_bit", int'(serial_data_out), int'(exp_bits.pop_front()));
      end
      run_len++;
    end else begin
      check("idle_line", int'(serial_data_out), 1);
      if (run_len > 0) begin
        if (exp_len.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got busy run %0d with no length queued", run_len);
        end else begin
          check("busy_len", run_len, exp_len.pop_front());
        end
        run_len = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("idle_timeout", int'(busy), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic pe, input logic pt,
                      input logic [10:0] frame, input int len);
    push_frame(frame, len);
    parallel_data = d;
    parity_enable = pe;
    parity_type   = pt;
    data_valid    = 1'b1;
    @(posedge clk);
    #1 data_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    send(8'hE6, 1'b1, 1'b0, 11'b1_1_11100110_0, 11);
    send(8'hFF, 1'b1, 1'b1, 11'b1_1_11111111_0, 11);
    send(8'hF4, 1'b0, 1'b0, 11'b0_1_11110100_0, 10);
    send(8'h01, 1'b1, 1'b1, 11'b1_0_00000001_0, 11);
    send(8'hFF, 1'b1, 1'b0, 11'b1_0_11111111_0, 11);
    repeat (2) @(posedge clk);
    #1;

    // Held valid: mid-frame input changes must not leak into the current frame.
    push_frame(11'b1_0_10100101_0, 11);
    push_frame(11'b1_1_00000000_0, 11);
    parallel_data = 8'hA5;
    parity_enable = 1'b1;
    parity_type   = 1'b0;
    data_valid    = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    parallel_data = 8'h00;
    parity_type   = 1'b1;
    repeat (9) @(posedge clk);
    #1 data_valid = 1'b0;
    wait_idle();
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of DATA.
    push_frame(11'b1_1_11100110_0, 11);
    parallel_data = 8'hE6;
    parity_enable = 1'b1;
    parity_type   = 1'b0;
    data_valid    = 1'b1;
    @(posedge clk);
    #1 data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("async_rst_line", int'(serial_data_out), 1);
    check("async_rst_busy", int'(busy), 0);
    exp_bits.delete();
    exp_len.delete();
    @(posedge clk);
    #3 reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    send(8'h3C, 1'b0, 1'b1, 11'b0_1_00111100_0, 10);
    repeat (2) @(negedge clk);

    check("leftover_bits", exp_bits.size(), 0);
    check("leftover_frames", exp_len.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
